instr_fetch_unit: RTL

- Instruction fetch and branch unit: the bus initiator that reads the 8-bit program memory.
- Drives `address_bus` from a program counter and samples the combinational `data_bus` reply.
- Assembles one- and two-byte instructions and resolves all branches (BRA, BHI, BEQ) locally.
- Issues only non-branch instructions to the execute stage over a valid/ready handshake.

---
 rtl/instr_fetch_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and branch unit: reads the 8-bit program memory, assembles one- and
// two-byte instructions, resolves BRA/BHI/BEQ locally and issues the rest to execute.
// Optional build macro: IFETCH_ILLEGAL_TRAP_EN (illegal opcodes trap instead of being skipped).
module instr_fetch_unit #(
    parameter logic [7:0] RESET_VECTOR = 8'd0
) (
    input  logic       program_clk,
    input  logic       reset,
    output logic [7:0] address_bus,
    input  logic [7:0] data_bus,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_byte,
    output logic [7:0] instr_imm,
    output logic       instr_has_imm,
    input  logic       exec_idle,
    input  logic       flag_z,
    input  logic       flag_hi,
    output logic       illegal_op
);

    // Six-bit opcodes of the bit7=1 class
    localparam logic [5:0] OpLdImm  = 6'b100000;
    localparam logic [5:0] OpCmp    = 6'b100011;
    localparam logic [5:0] OpDec    = 6'b100101;
    localparam logic [5:0] OpInput  = 6'b100110;
    localparam logic [5:0] OpOutput = 6'b100111;
    localparam logic [5:0] OpBra    = 6'b101010;
    localparam logic [5:0] OpBhi    = 6'b101100;
    localparam logic [5:0] OpBeq    = 6'b101101;

    typedef enum logic [2:0] {
        StFetchOp,
        StFetchImm,
        StBrWait,
        StIssue,
        StTrap
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] op_q, op_d;
    logic [7:0] imm_q, imm_d;
    logic       has_imm_q, has_imm_d;
    logic       op_is_bra;
    logic       op_is_cond;
    logic       br_taken;

    function automatic logic is_two_byte(input logic [7:0] b);
        return b[7] && (b[7:2] inside {OpLdImm, OpCmp, OpBra, OpBhi, OpBeq});
    endfunction

    function automatic logic is_legal(input logic [7:0] b);
        if (!b[7]) begin
            return b[7:4] inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0111};
        end
        return is_two_byte(b) || (b[7:2] inside {OpDec, OpInput, OpOutput});
    endfunction

    // Branch decode always refers to the latched opcode
    assign op_is_bra  = (op_q[7:2] == OpBra);
    assign op_is_cond = (op_q[7:2] == OpBhi) || (op_q[7:2] == OpBeq);
    assign br_taken   = (op_q[7:2] == OpBhi) ? flag_hi : flag_z;

    // State register
    always_ff @(posedge program_clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetchOp;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetchOp: begin
                if (!is_legal(data_bus)) begin
`ifdef IFETCH_ILLEGAL_TRAP_EN
                    state_d = StTrap;
`else
                    state_d = StFetchOp;
`endif
                end else if (is_two_byte(data_bus)) begin
                    state_d = StFetchImm;
                end else begin
                    state_d = StIssue;
                end
            end
            StFetchImm: begin
                if (op_is_bra) begin
                    state_d = StFetchOp;
                end else if (op_is_cond) begin
                    state_d = StBrWait;
                end else begin
                    state_d = StIssue;
                end
            end
            StBrWait: begin
                if (exec_idle) begin
                    state_d = StFetchOp;
                end
            end
            StIssue: begin
                // instr_valid is high in this state, so ready alone completes the handshake
                if (instr_ready) begin
                    state_d = StFetchOp;
                end
            end
`ifdef IFETCH_ILLEGAL_TRAP_EN
            StTrap: state_d = StTrap;
`endif
            default: state_d = StFetchOp;
        endcase
    end

    // Datapath registers: PC, opcode, immediate
    always_ff @(posedge program_clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR;
            op_q      <= 8'd0;
            imm_q     <= 8'd0;
            has_imm_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            op_q      <= op_d;
            imm_q     <= imm_d;
            has_imm_q <= has_imm_d;
        end
    end

    // Datapath next-state: PC only moves on fetch cycles and branch resolution
    always_comb begin
        pc_d      = pc_q;
        op_d      = op_q;
        imm_d     = imm_q;
        has_imm_d = has_imm_q;
        case (state_q)
            StFetchOp: begin
                pc_d      = pc_q + 8'd1;
                op_d      = data_bus;
                imm_d     = 8'd0;
                has_imm_d = is_two_byte(data_bus);
            end
            StFetchImm: begin
                imm_d = data_bus;
                pc_d  = op_is_bra ? data_bus : pc_q + 8'd1;
            end
            StBrWait: begin
                // Not taken leaves PC already pointing past the immediate
                if (exec_idle && br_taken) begin
                    pc_d = imm_q;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state and held registers
    always_comb begin
        instr_valid = (state_q == StIssue);
`ifdef IFETCH_ILLEGAL_TRAP_EN
        illegal_op  = (state_q == StTrap);
`else
        illegal_op  = 1'b0;
`endif
    end

    assign address_bus   = pc_q;
    assign instr_byte    = op_q;
    assign instr_imm     = imm_q;
    assign instr_has_imm = has_imm_q;

endmodule
